// File: rtl/reorder_buffer_param_if.sv
// Issue / write-back / commit bus of the reorder buffer.
// The master side drives allocation requests, CDB results and memory
// acceptance. The slave side (the buffer) returns occupancy and commit effects.
interface reorder_buffer_param_if #(
  parameter int WORD_SIZE = 32,
  parameter int REG_INDEX = 5,
  parameter int RB_INDEX  = 3,
  parameter int WB_PORTS  = 2
);
  // issue
  logic                          alloc_valid;
  logic [1:0]                    alloc_kind;
  logic [REG_INDEX-1:0]          alloc_rdest;
  logic                          alloc_ready;
  logic [RB_INDEX-1:0]           alloc_tag;
  // write-back
  logic [WB_PORTS-1:0]           cdb_valid;
  logic [WB_PORTS*RB_INDEX-1:0]  cdb_tag;
  logic [WB_PORTS*WORD_SIZE-1:0] cdb_data;
  logic [WB_PORTS*WORD_SIZE-1:0] cdb_addr;
  // commit
  logic                          reg_we;
  logic [REG_INDEX-1:0]          reg_ws;
  logic [WORD_SIZE-1:0]          reg_wd;
  logic [RB_INDEX-1:0]           reg_tag;
  logic                          mem_valid;
  logic [WORD_SIZE-1:0]          mem_addr;
  logic [WORD_SIZE-1:0]          mem_data;
  logic                          mem_ready;
  logic                          flush;
  logic [WORD_SIZE-1:0]          flush_pc;
  logic                          halted;
  logic [RB_INDEX:0]             count;

  modport master (
    output alloc_valid, alloc_kind, alloc_rdest, cdb_valid, cdb_tag, cdb_data, cdb_addr, mem_ready,
    input  alloc_ready, alloc_tag, reg_we, reg_ws, reg_wd, reg_tag, mem_valid, mem_addr, mem_data,
           flush, flush_pc, halted, count
  );

  modport slave (
    input  alloc_valid, alloc_kind, alloc_rdest, cdb_valid, cdb_tag, cdb_data, cdb_addr, mem_ready,
    output alloc_ready, alloc_tag, reg_we, reg_ws, reg_wd, reg_tag, mem_valid, mem_addr, mem_data,
           flush, flush_pc, halted, count
  );
endinterface

// File: rtl/reorder_buffer_param.sv
// Parameterised in-order-commit reorder buffer.
// Entries are allocated at the tail, completed out of order over WB_PORTS
// CDB ports, and retired one per cycle from the head as a register write,
// a store handshake, a branch resolution (possibly flushing) or a halt.
module reorder_buffer_param #(
  parameter int WORD_SIZE = 32,
  parameter int REG_INDEX = 5,
  parameter int RB_SIZE   = 8,
  parameter int WB_PORTS  = 2
) (
  input logic                   clk,
  input logic                   reset,
  reorder_buffer_param_if.slave bus
);
  localparam int RB_INDEX = $clog2(RB_SIZE);

  typedef logic [RB_INDEX-1:0] idx_t;
  typedef logic [RB_INDEX:0]   cnt_t;
  typedef enum logic [1:0] {KIND_REG, KIND_STORE, KIND_BRANCH, KIND_HALT} kind_e;

  localparam cnt_t FULL = cnt_t'(RB_SIZE);

  // pointers, occupancy and per-entry status
  idx_t                 head_q, head_d, tail_q, tail_d;
  cnt_t                 count_q, count_d;
  logic [RB_SIZE-1:0]   valid_q, valid_d, done_q, done_d;
  logic                 halted_q, halted_d;
  // per-entry payload
  kind_e                kind_q  [RB_SIZE];
  kind_e                kind_d  [RB_SIZE];
  logic [REG_INDEX-1:0] rdest_q [RB_SIZE];
  logic [REG_INDEX-1:0] rdest_d [RB_SIZE];
  logic [WORD_SIZE-1:0] data_q  [RB_SIZE];
  logic [WORD_SIZE-1:0] data_d  [RB_SIZE];
  logic [WORD_SIZE-1:0] addr_q  [RB_SIZE];
  logic [WORD_SIZE-1:0] addr_d  [RB_SIZE];
  // registered commit outputs
  logic                 reg_we_q, reg_we_d, mem_valid_q, mem_valid_d, flush_q, flush_d;
  logic [REG_INDEX-1:0] reg_ws_q, reg_ws_d;
  logic [WORD_SIZE-1:0] reg_wd_q, reg_wd_d, mem_addr_q, mem_addr_d;
  logic [WORD_SIZE-1:0] mem_data_q, mem_data_d, flush_pc_q, flush_pc_d;
  idx_t                 reg_tag_q, reg_tag_d;

  idx_t head_next, cdb_t;
  logic head_ready, flush_pending, alloc_ready, accept, free_head, take_flush;

  assign head_next     = head_q + 1'b1;
  assign head_ready    = valid_q[head_q] && done_q[head_q] && !halted_q;
  assign flush_pending = valid_q[head_q] && done_q[head_q] &&
                         (kind_q[head_q] == KIND_BRANCH) && (data_q[head_q] != '0);
  assign alloc_ready   = (count_q < FULL) && !halted_q && !flush_pending;
  assign accept        = bus.alloc_valid && alloc_ready;

  // Next-state: CDB capture, then allocation, then head commit, then flush override.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    head_d      = head_q;
    tail_d      = tail_q;
    count_d     = count_q;
    valid_d     = valid_q;
    done_d      = done_q;
    halted_d    = halted_q;
    kind_d      = kind_q;
    rdest_d     = rdest_q;
    data_d      = data_q;
    addr_d      = addr_q;
    reg_we_d    = 1'b0;
    reg_ws_d    = reg_ws_q;
    reg_wd_d    = reg_wd_q;
    reg_tag_d   = reg_tag_q;
    mem_valid_d = mem_valid_q;
    mem_addr_d  = mem_addr_q;
    mem_data_d  = mem_data_q;
    flush_d     = 1'b0;
    flush_pc_d  = flush_pc_q;
    free_head   = 1'b0;
    take_flush  = 1'b0;
    cdb_t       = '0;

    // Walk ports high to low so the lowest-numbered port's write lands last.
    for (int p = WB_PORTS - 1; p >= 0; p--) begin
      if (bus.cdb_valid[p]) begin
        cdb_t = bus.cdb_tag[p*RB_INDEX +: RB_INDEX];
        if (valid_q[cdb_t] && !done_q[cdb_t]) begin
          done_d[cdb_t] = 1'b1;
          data_d[cdb_t] = bus.cdb_data[p*WORD_SIZE +: WORD_SIZE];
          addr_d[cdb_t] = bus.cdb_addr[p*WORD_SIZE +: WORD_SIZE];
        end
      end
    end

    if (accept) begin
      valid_d[tail_q] = 1'b1;
      kind_d[tail_q]  = kind_e'(bus.alloc_kind);
      done_d[tail_q]  = (kind_e'(bus.alloc_kind) == KIND_HALT);
      rdest_d[tail_q] = bus.alloc_rdest;
      tail_d          = tail_q + 1'b1;
    end

    if (mem_valid_q) begin
      // A store is being offered; the head only retires once memory accepts it.
      if (bus.mem_ready) begin
        free_head = 1'b1;
        if (valid_q[head_next] && done_q[head_next] && (kind_q[head_next] == KIND_STORE)) begin
          mem_addr_d = addr_q[head_next];
          mem_data_d = data_q[head_next];
        end else begin
          mem_valid_d = 1'b0;
        end
      end
    end else if (head_ready) begin
      unique case (kind_q[head_q])
        KIND_REG: begin
          reg_we_d  = 1'b1;
          reg_ws_d  = rdest_q[head_q];
          reg_wd_d  = data_q[head_q];
          reg_tag_d = head_q;
          free_head = 1'b1;
        end
        KIND_STORE: begin
          mem_valid_d = 1'b1;
          mem_addr_d  = addr_q[head_q];
          mem_data_d  = data_q[head_q];
        end
        KIND_BRANCH: begin
          if (data_q[head_q] != '0) begin
            take_flush = 1'b1;
            flush_d    = 1'b1;
            flush_pc_d = addr_q[head_q];
          end else begin
            free_head = 1'b1;
          end
        end
        KIND_HALT: halted_d = 1'b1;
      endcase
    end

    if (take_flush) begin
      // Everything younger than the branch is wrong-path work.
      valid_d = '0;
      done_d  = '0;
      head_d  = head_next;
      tail_d  = head_next;
      count_d = '0;
    end else begin
      if (free_head) begin
        valid_d[head_q] = 1'b0;
        done_d[head_q]  = 1'b0;
        head_d          = head_next;
      end
      unique case ({accept, free_head})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // Control state and commit outputs, cleared by synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    if (reset) begin
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      valid_q     <= '0;
      done_q      <= '0;
      halted_q    <= 1'b0;
      reg_we_q    <= 1'b0;
      reg_ws_q    <= '0;
      reg_wd_q    <= '0;
      reg_tag_q   <= '0;
      mem_valid_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_data_q  <= '0;
      flush_q     <= 1'b0;
      flush_pc_q  <= '0;
    end else begin
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      valid_q     <= valid_d;
      done_q      <= done_d;
      halted_q    <= halted_d;
      reg_we_q    <= reg_we_d;
      reg_ws_q    <= reg_ws_d;
      reg_wd_q    <= reg_wd_d;
      reg_tag_q   <= reg_tag_d;
      mem_valid_q <= mem_valid_d;
      mem_addr_q  <= mem_addr_d;
      mem_data_q  <= mem_data_d;
      flush_q     <= flush_d;
      flush_pc_q  <= flush_pc_d;
    end
  end

  // Entry payload storage.
  always_ff @(posedge clk) begin
    // NOTE: payload is not reset; it is only ever read when the entry's valid bit is set.
    kind_q  <= kind_d;
    rdest_q <= rdest_d;
    data_q  <= data_d;
    addr_q  <= addr_d;
  end

  assign bus.alloc_ready = alloc_ready;
  assign bus.alloc_tag   = tail_q;
  assign bus.reg_we      = reg_we_q;
  assign bus.reg_ws      = reg_ws_q;
  assign bus.reg_wd      = reg_wd_q;
  assign bus.reg_tag     = reg_tag_q;
  assign bus.mem_valid   = mem_valid_q;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.mem_data    = mem_data_q;
  assign bus.flush       = flush_q;
  assign bus.flush_pc    = flush_pc_q;
  assign bus.halted      = halted_q;
  assign bus.count       = count_q;
endmodule

// File: tb/tb_reorder_buffer_param.sv
// Directed testbench for reorder_buffer_param (default parameters).
module tb_reorder_buffer_param;
  localparam int WS  = 32;
  localparam int RI  = 5;
  localparam int RBI = 3;
  localparam int WBP = 2;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  reorder_buffer_param_if #(.WORD_SIZE(WS), .REG_INDEX(RI), .RB_INDEX(RBI), .WB_PORTS(WBP)) bus ();

  reorder_buffer_param #(.WORD_SIZE(WS), .REG_INDEX(RI), .RB_SIZE(8), .WB_PORTS(WBP)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.alloc_valid = 1'b0;
    bus.alloc_kind  = 2'd0;
    bus.alloc_rdest = '0;
    bus.cdb_valid   = '0;
    bus.cdb_tag     = '0;
    bus.cdb_data    = '0;
    bus.cdb_addr    = '0;
  endtask

  task automatic set_alloc(input logic [1:0] kind, input logic [RI-1:0] rdest);
    bus.alloc_valid = 1'b1;
    bus.alloc_kind  = kind;
    bus.alloc_rdest = rdest;
  endtask

  task automatic set_cdb(input int p, input logic [RBI-1:0] tag, input logic [WS-1:0] data,
                         input logic [WS-1:0] addr);
    bus.cdb_valid[p]           = 1'b1;
    bus.cdb_tag[p*RBI +: RBI]  = tag;
    bus.cdb_data[p*WS +: WS]   = data;
    bus.cdb_addr[p*WS +: WS]   = addr;
  endtask

  task automatic do_reset();
    idle();
    bus.mem_ready = 1'b0;
    reset = 1'b1;
    cycle();
    cycle();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (bus.count !== 4'd0) begin errors++; $display("FAIL reset_count: got %0d exp 0", bus.count); end
    checks++; if (bus.alloc_ready !== 1'b1) begin errors++; $display("FAIL reset_alloc_ready: got %b exp 1", bus.alloc_ready); end
    checks++; if (bus.alloc_tag !== 3'd0) begin errors++; $display("FAIL reset_alloc_tag: got %0d exp 0", bus.alloc_tag); end
    checks++; if ({bus.reg_we, bus.mem_valid, bus.flush, bus.halted} !== 4'b0) begin errors++;
      $display("FAIL reset_strobes: got %b exp 0000", {bus.reg_we, bus.mem_valid, bus.flush, bus.halted}); end
  endtask

  task automatic test_reg_commit();
    do_reset();
    set_alloc(2'd0, 5'd3);
    checks++; if (bus.alloc_tag !== 3'd0) begin errors++; $display("FAIL reg_alloc_tag: got %0d exp 0", bus.alloc_tag); end
    cycle();
    idle();
    set_cdb(1, 3'd0, 32'h55, 32'h0);
    checks++; if (bus.count !== 4'd1) begin errors++; $display("FAIL reg_count1: got %0d exp 1", bus.count); end
    cycle();
    idle();
    checks++; if (bus.reg_we !== 1'b0) begin errors++; $display("FAIL reg_we_early: got %b exp 0", bus.reg_we); end
    cycle();
    checks++; if (bus.reg_we !== 1'b1) begin errors++; $display("FAIL reg_we: got %b exp 1", bus.reg_we); end
    checks++; if (bus.reg_ws !== 5'd3) begin errors++; $display("FAIL reg_ws: got %0d exp 3", bus.reg_ws); end
    checks++; if (bus.reg_wd !== 32'h55) begin errors++; $display("FAIL reg_wd: got %0h exp 55", bus.reg_wd); end
    checks++; if (bus.reg_tag !== 3'd0) begin errors++; $display("FAIL reg_tag: got %0d exp 0", bus.reg_tag); end
    checks++; if (bus.count !== 4'd0) begin errors++; $display("FAIL reg_count0: got %0d exp 0", bus.count); end
    checks++; if (bus.mem_valid !== 1'b0) begin errors++; $display("FAIL reg_mem_valid: got %b exp 0", bus.mem_valid); end
    cycle();
    checks++; if (bus.reg_we !== 1'b0) begin errors++; $display("FAIL reg_we_pulse: got %b exp 0", bus.reg_we); end
  endtask

  task automatic test_full_wrap();
    do_reset();
    for (int i = 0; i < 8; i++) begin
      checks++; if (bus.alloc_tag !== 3'(i)) begin errors++; $display("FAIL full_alloc_tag: got %0d exp %0d", bus.alloc_tag, i); end
      set_alloc(2'd0, 5'(i + 1));
      cycle();
    end
    idle();
    checks++; if (bus.count !== 4'd8) begin errors++; $display("FAIL full_count: got %0d exp 8", bus.count); end
    checks++; if (bus.alloc_ready !== 1'b0) begin errors++; $display("FAIL full_alloc_ready: got %b exp 0", bus.alloc_ready); end
    set_cdb(0, 3'd0, 32'hA0, 32'h0);
    cycle();
    idle();
    cycle();
    checks++; if (bus.reg_tag !== 3'd0 || bus.reg_we !== 1'b1) begin errors++;
      $display("FAIL full_commit0: got we=%b tag=%0d exp we=1 tag=0", bus.reg_we, bus.reg_tag); end
    checks++; if (bus.count !== 4'd7) begin errors++; $display("FAIL full_count7: got %0d exp 7", bus.count); end
    checks++; if (bus.alloc_ready !== 1'b1) begin errors++; $display("FAIL full_ready_again: got %b exp 1", bus.alloc_ready); end
    checks++; if (bus.alloc_tag !== 3'd0) begin errors++; $display("FAIL full_wrap_tag: got %0d exp 0", bus.alloc_tag); end
    set_cdb(0, 3'd1, 32'hA1, 32'h0);
    cycle();
    idle();
    set_alloc(2'd0, 5'd9);
    cycle();
    idle();
    checks++; if (bus.count !== 4'd7) begin errors++; $display("FAIL simul_count: got %0d exp 7", bus.count); end
    checks++; if (bus.reg_tag !== 3'd1 || bus.reg_wd !== 32'hA1) begin errors++;
      $display("FAIL simul_commit: got tag=%0d wd=%0h exp tag=1 wd=a1", bus.reg_tag, bus.reg_wd); end
    checks++; if (bus.alloc_tag !== 3'd1) begin errors++; $display("FAIL simul_tail: got %0d exp 1", bus.alloc_tag); end
  endtask

  task automatic test_out_of_order();
    logic [WS-1:0] exp_wd [3];
    exp_wd[0] = 32'h10;
    exp_wd[1] = 32'h11;
    exp_wd[2] = 32'h22;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      set_alloc(2'd0, 5'(i + 1));
      cycle();
    end
    for (int i = 2; i >= 0; i--) begin
      idle();
      set_cdb(0, 3'(i), exp_wd[i], 32'h0);
      cycle();
    end
    idle();
    checks++; if (bus.reg_we !== 1'b0) begin errors++; $display("FAIL ooo_no_commit: got %b exp 0", bus.reg_we); end
    for (int i = 0; i < 3; i++) begin
      cycle();
      checks++; if (bus.reg_we !== 1'b1 || bus.reg_tag !== 3'(i) || bus.reg_wd !== exp_wd[i] || bus.reg_ws !== 5'(i + 1)) begin
        errors++;
        $display("FAIL ooo_commit%0d: got we=%b tag=%0d wd=%0h ws=%0d exp we=1 tag=%0d wd=%0h ws=%0d",
                 i, bus.reg_we, bus.reg_tag, bus.reg_wd, bus.reg_ws, i, exp_wd[i], i + 1);
      end
    end
    checks++; if (bus.count !== 4'd0) begin errors++; $display("FAIL ooo_count: got %0d exp 0", bus.count); end
  endtask

  task automatic test_port_priority();
    do_reset();
    set_alloc(2'd0, 5'd7);
    cycle();
    idle();
    set_cdb(0, 3'd0, 32'hAA, 32'h0);
    set_cdb(1, 3'd0, 32'hBB, 32'h0);
    cycle();
    idle();
    set_cdb(1, 3'd0, 32'hCC, 32'h0);
    cycle();
    idle();
    checks++; if (bus.reg_we !== 1'b1 || bus.reg_wd !== 32'hAA) begin errors++;
      $display("FAIL port_priority: got we=%b wd=%0h exp we=1 wd=aa", bus.reg_we, bus.reg_wd); end
  endtask

  task automatic test_store();
    do_reset();
    set_alloc(2'd1, 5'd0);
    cycle();
    idle();
    set_cdb(0, 3'd0, 32'h7, 32'h10);
    cycle();
    idle();
    checks++; if (bus.mem_valid !== 1'b0) begin errors++; $display("FAIL store_early: got %b exp 0", bus.mem_valid); end
    cycle();
    for (int i = 0; i < 4; i++) begin
      checks++; if (bus.mem_valid !== 1'b1 || bus.mem_addr !== 32'h10 || bus.mem_data !== 32'h7 || bus.count !== 4'd1) begin
        errors++;
        $display("FAIL store_hold%0d: got v=%b a=%0h d=%0h cnt=%0d exp v=1 a=10 d=7 cnt=1",
                 i, bus.mem_valid, bus.mem_addr, bus.mem_data, bus.count);
      end
      checks++; if (bus.reg_we !== 1'b0) begin errors++; $display("FAIL store_reg_we: got %b exp 0", bus.reg_we); end
      if (i < 3) cycle();
    end
    bus.mem_ready = 1'b1;
    cycle();
    bus.mem_ready = 1'b0;
    checks++; if (bus.count !== 4'd0) begin errors++; $display("FAIL store_freed: got %0d exp 0", bus.count); end
    checks++; if (bus.mem_valid !== 1'b0) begin errors++; $display("FAIL store_valid_fall: got %b exp 0", bus.mem_valid); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    set_alloc(2'd1, 5'd0);
    cycle();
    set_alloc(2'd1, 5'd0);
    cycle();
    idle();
    set_cdb(0, 3'd0, 32'h1, 32'h100);
    set_cdb(1, 3'd1, 32'h2, 32'h104);
    cycle();
    idle();
    bus.mem_ready = 1'b1;
    cycle();
    checks++; if (bus.mem_valid !== 1'b1 || bus.mem_addr !== 32'h100 || bus.count !== 4'd2) begin errors++;
      $display("FAIL b2b_first: got v=%b a=%0h cnt=%0d exp v=1 a=100 cnt=2", bus.mem_valid, bus.mem_addr, bus.count); end
    cycle();
    checks++; if (bus.mem_valid !== 1'b1 || bus.mem_addr !== 32'h104 || bus.mem_data !== 32'h2 || bus.count !== 4'd1) begin errors++;
      $display("FAIL b2b_second: got v=%b a=%0h d=%0h cnt=%0d exp v=1 a=104 d=2 cnt=1",
               bus.mem_valid, bus.mem_addr, bus.mem_data, bus.count); end
    cycle();
    bus.mem_ready = 1'b0;
    checks++; if (bus.mem_valid !== 1'b0 || bus.count !== 4'd0) begin errors++;
      $display("FAIL b2b_done: got v=%b cnt=%0d exp v=0 cnt=0", bus.mem_valid, bus.count); end
  endtask

  task automatic test_reset_mid_store();
    do_reset();
    set_alloc(2'd1, 5'd0);
    cycle();
    idle();
    set_cdb(0, 3'd0, 32'h9, 32'h30);
    cycle();
    idle();
    cycle();
    checks++; if (bus.mem_valid !== 1'b1) begin errors++; $display("FAIL midrst_pending: got %b exp 1", bus.mem_valid); end
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    checks++; if (bus.mem_valid !== 1'b0 || bus.mem_addr !== 32'h0 || bus.count !== 4'd0) begin errors++;
      $display("FAIL midrst_clear: got v=%b a=%0h cnt=%0d exp v=0 a=0 cnt=0", bus.mem_valid, bus.mem_addr, bus.count); end
  endtask

  task automatic test_flush();
    logic [1:0] kinds [5];
    kinds[0] = 2'd0; kinds[1] = 2'd2; kinds[2] = 2'd0; kinds[3] = 2'd0; kinds[4] = 2'd0;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      set_alloc(kinds[i], 5'(i + 1));
      cycle();
    end
    idle();
    checks++; if (bus.count !== 4'd5) begin errors++; $display("FAIL flush_count5: got %0d exp 5", bus.count); end
    set_cdb(0, 3'd0, 32'h1, 32'h0);
    set_cdb(1, 3'd1, 32'h1, 32'h40);
    cycle();
    idle();
    cycle();
    checks++; if (bus.reg_we !== 1'b1 || bus.count !== 4'd4) begin errors++;
      $display("FAIL flush_pre_commit: got we=%b cnt=%0d exp we=1 cnt=4", bus.reg_we, bus.count); end
    checks++; if (bus.alloc_ready !== 1'b0) begin errors++; $display("FAIL flush_pending_ready: got %b exp 0", bus.alloc_ready); end
    set_alloc(2'd0, 5'd6);
    set_cdb(0, 3'd3, 32'h77, 32'h0);
    cycle();
    idle();
    checks++; if (bus.flush !== 1'b1 || bus.flush_pc !== 32'h40) begin errors++;
      $display("FAIL flush_pulse: got f=%b pc=%0h exp f=1 pc=40", bus.flush, bus.flush_pc); end
    checks++; if (bus.count !== 4'd0 || bus.alloc_tag !== 3'd2) begin errors++;
      $display("FAIL flush_ptrs: got cnt=%0d tail=%0d exp cnt=0 tail=2", bus.count, bus.alloc_tag); end
    checks++; if (bus.reg_we !== 1'b0) begin errors++; $display("FAIL flush_reg_we: got %b exp 0", bus.reg_we); end
    set_cdb(0, 3'd3, 32'h33, 32'h0);
    cycle();
    idle();
    checks++; if (bus.flush !== 1'b0 || bus.alloc_ready !== 1'b1) begin errors++;
      $display("FAIL flush_one_cycle: got f=%b ready=%b exp f=0 ready=1", bus.flush, bus.alloc_ready); end
    cycle();
    checks++; if (bus.reg_we !== 1'b0 || bus.count !== 4'd0) begin errors++;
      $display("FAIL flush_stale_cdb: got we=%b cnt=%0d exp we=0 cnt=0", bus.reg_we, bus.count); end
  endtask

  task automatic test_halt_reset();
    do_reset();
    set_alloc(2'd1, 5'd0);
    cycle();
    set_alloc(2'd3, 5'd0);
    cycle();
    idle();
    set_cdb(0, 3'd0, 32'h5, 32'h20);
    cycle();
    idle();
    cycle();
    checks++; if (bus.mem_valid !== 1'b1 || bus.halted !== 1'b0) begin errors++;
      $display("FAIL halt_store_pending: got v=%b h=%b exp v=1 h=0", bus.mem_valid, bus.halted); end
    cycle();
    bus.mem_ready = 1'b1;
    cycle();
    bus.mem_ready = 1'b0;
    checks++; if (bus.mem_valid !== 1'b0 || bus.count !== 4'd1 || bus.halted !== 1'b0) begin errors++;
      $display("FAIL halt_store_done: got v=%b cnt=%0d h=%b exp v=0 cnt=1 h=0", bus.mem_valid, bus.count, bus.halted); end
    cycle();
    checks++; if (bus.halted !== 1'b1 || bus.count !== 4'd1) begin errors++;
      $display("FAIL halt_set: got h=%b cnt=%0d exp h=1 cnt=1", bus.halted, bus.count); end
    checks++; if (bus.alloc_ready !== 1'b0) begin errors++; $display("FAIL halt_ready: got %b exp 0", bus.alloc_ready); end
    set_alloc(2'd0, 5'd4);
    cycle();
    idle();
    checks++; if (bus.count !== 4'd1 || bus.halted !== 1'b1) begin errors++;
      $display("FAIL halt_blocked: got cnt=%0d h=%b exp cnt=1 h=1", bus.count, bus.halted); end
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    checks++; if ({bus.halted, bus.reg_we, bus.mem_valid, bus.flush} !== 4'b0 || bus.count !== 4'd0) begin errors++;
      $display("FAIL halt_rst_strobes: got h/we/mv/f=%b cnt=%0d exp 0000 cnt=0",
               {bus.halted, bus.reg_we, bus.mem_valid, bus.flush}, bus.count); end
    checks++; if (bus.mem_addr !== 32'h0 || bus.mem_data !== 32'h0 || bus.flush_pc !== 32'h0 ||
                  bus.reg_ws !== 5'd0 || bus.reg_wd !== 32'h0 || bus.reg_tag !== 3'd0) begin errors++;
      $display("FAIL halt_rst_buses: got ma=%0h md=%0h pc=%0h ws=%0d wd=%0h tag=%0d exp all 0",
               bus.mem_addr, bus.mem_data, bus.flush_pc, bus.reg_ws, bus.reg_wd, bus.reg_tag); end
    checks++; if (bus.alloc_ready !== 1'b1) begin errors++; $display("FAIL halt_rst_ready: got %b exp 1", bus.alloc_ready); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    idle();
    bus.mem_ready = 1'b0;
    test_reset();
    test_reg_commit();
    test_full_wrap();
    test_out_of_order();
    test_port_priority();
    test_store();
    test_back_to_back();
    test_reset_mid_store();
    test_flush();
    test_halt_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/reorder_buffer_param.md
REORDER_BUFFER_PARAM -- requirements
Module: reorder_buffer_param

Interface
REQ-001 Parameter WORD_SIZE, default 32, data/address/PC width.
REQ-002 Parameter REG_INDEX, default 5, architectural register index width.
REQ-003 Parameter RB_SIZE, default 8, entry count; power of two, at least 2; RB_INDEX = log2(RB_SIZE).
REQ-004 Parameter WB_PORTS, default 2, number of independent CDB write-back ports.
REQ-005 clk  in  1  single clock; all state updates on posedge.
REQ-006 reset  in  1  synchronous, active-high reset, sampled on posedge clk.
REQ-007 alloc_valid  in  1  issue stage requests an entry.
REQ-008 alloc_kind  in  2  entry kind: 0 = REG, 1 = STORE, 2 = BRANCH, 3 = HALT.
REQ-009 alloc_rdest  in  REG_INDEX  destination register; used only for REG.
REQ-010 alloc_ready  out  1  entry can be accepted this cycle (combinational).
REQ-011 alloc_tag  out  RB_INDEX  index that the accepted entry receives (= tail).
REQ-012 cdb_valid  in  WB_PORTS  per-port result strobe.
REQ-013 cdb_tag  in  WB_PORTS*RB_INDEX  per-port target entry; port p uses slice p.
REQ-014 cdb_data  in  WB_PORTS*WORD_SIZE  per-port result; for BRANCH, nonzero means taken.
REQ-015 cdb_addr  in  WB_PORTS*WORD_SIZE  per-port store address or branch target.
REQ-016 reg_we, reg_ws, reg_wd, reg_tag  out  1, REG_INDEX, WORD_SIZE, RB_INDEX  registered register-commit pulse; reg_tag is the committing index, used by register status to clear only on a match.
REQ-017 mem_valid, mem_addr, mem_data  out  1, WORD_SIZE, WORD_SIZE  store commit request.
REQ-018 mem_ready  in  1  memory accepts the store when high together with mem_valid.
REQ-019 flush, flush_pc  out  1, WORD_SIZE  registered one-cycle redirect on a taken branch.
REQ-020 halted  out  1  sticky; set when HALT commits.
REQ-021 count  out  RB_INDEX+1  number of occupied entries.

Function
REQ-022 Circular buffer: head = oldest entry, tail = next free entry; both wrap modulo RB_SIZE; count tracks occupancy exactly, so full (count == RB_SIZE) and empty (count == 0) are distinguishable.
REQ-023 alloc_ready = (count < RB_SIZE) && !halted && !flush_pending, where flush_pending means the head is a done, taken BRANCH; alloc_ready does not depend on a commit in the same cycle.
REQ-024 Accept (alloc_valid && alloc_ready) writes kind and rdest at tail, sets valid = 1 and done = 0 (done = 1 for HALT), then increments tail.
REQ-025 CDB: for each port with cdb_valid, the entry at cdb_tag captures data and addr and sets done = 1, but only if that entry is valid and not yet done; writes to invalid entries are silently dropped.
REQ-026 Two ports targeting the same tag in one cycle: the lowest-numbered port wins.
REQ-027 Commit evaluates the head entry only if it is valid and done at the clock edge; at most one commit per cycle.
REQ-028 REG commit: for the next cycle, reg_we = 1 with reg_ws = rdest, reg_wd = data, reg_tag = head; the head entry is freed.
REQ-029 STORE commit: mem_valid = 1 with addr and data from the entry.
REQ-030 STORE handshake: mem_valid, mem_addr and mem_data stay stable until the cycle in which mem_ready = 1; the entry is freed on that edge; mem_valid falls the following cycle unless the next head is also a done STORE (back-to-back).
REQ-031 BRANCH not taken: entry is freed with no side effects.
REQ-032 BRANCH taken: flush = 1 and flush_pc = addr for one cycle; every entry is invalidated; head = tail = index after the branch; count = 0; same-edge CDB writes and allocations are discarded.
REQ-033 HALT at head: halted = 1; head is not advanced; no further allocations or commits until reset.
REQ-034 Simultaneous allocate and commit: count remains unchanged; both pointers advance.
REQ-035 Minimum latency: accepted at edge k, CDB at edge k+1, reg_we high in the cycle after edge k+2.
REQ-036 When a STORE entry commits, reg_we is 0; when a REG entry commits, mem_valid is 0.

Reset
REQ-037 On reset: head = tail = 0, count = 0, all valid/done cleared; reg_we, mem_valid, flush and halted = 0; reg_ws, reg_wd, reg_tag, mem_addr, mem_data and flush_pc = 0.
REQ-038 Reset in any cycle, including an outstanding store handshake or a flush cycle, takes priority over every other update; mem_valid is 0 in the cycle after the reset edge.

Verification
REQ-039 Allocate REG rdest 3 (tag 0); drive CDB port 1 with tag 0, data 0x55 -> reg_we = 1, reg_ws = 3, reg_wd = 0x55, reg_tag = 0 two cycles after the CDB edge; count returns to 0.
REQ-040 Allocate 8 entries with RB_SIZE = 8 -> alloc_ready = 0 and count = 8; complete tag 0 -> alloc_ready returns to 1; next alloc_tag = 0 (wrap-around).
REQ-041 Tags 0..2 REG with CDB completing them in order 2, 1, 0 -> commits occur in order 0, 1, 2, one per cycle.
REQ-042 STORE addr 0x10, data 0x7; hold mem_ready = 0 for 3 cycles -> mem_valid, mem_addr and mem_data stay stable; entry frees only on the mem_ready = 1 edge.
REQ-043 BRANCH at tag 1 taken to 0x40, with tags 2..4 valid -> flush = 1 for one cycle, flush_pc = 0x40, count = 0; a later CDB write to tag 3 is ignored.
REQ-044 HALT committed while a store is pending, then reset -> halted = 1 and allocations are blocked; after the reset edge all outputs are 0 and count = 0.
